// File: rtl/vga_stream_pkg.sv
// Shared types and constants for the VGA-domain frame streaming path.
// Beat layout follows the Avalon-ST video packet: pixel plus packet delimiters.
package vga_stream_pkg;

  localparam int DEF_WIDTH    = 320;
  localparam int DEF_HEIGHT   = 240;
  localparam int PIX_W        = 12;
  localparam int DEF_ADDR_W   = 17;
  localparam int FRAME_PIXELS = DEF_WIDTH * DEF_HEIGHT;
  localparam int FIFO_DEPTH   = 3;

  typedef logic [PIX_W-1:0] pixel_t;

  typedef struct packed {
    pixel_t data;
    logic   sop;
    logic   eop;
  } beat_t;

  typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_DRAIN} state_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_skid_fifo.sv
// Small circular skid FIFO of beats; head is visible combinationally, push lands next cycle.
// Never asserts back-pressure itself: the producer's credit rule keeps it from overflowing.
module stream_skid_fifo
  import vga_stream_pkg::*;
#(
  parameter  int DEPTH = FIFO_DEPTH,
  localparam int PW    = cnt_w(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  beat_t         push_beat,
  input  logic          pop,
  output beat_t         head,
  output logic [CW-1:0] count
);

  beat_t         mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage is cleared too, so an empty FIFO presents an all-zero head.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_beat;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (pop) rd_ptr <= nxt(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/frame_streamer.sv
// Raster-reads the frame buffer and emits it as an Avalon-ST packet; 2-cycle issue-to-valid latency.
// Sink back-pressure is absorbed by a 3-entry skid FIFO with credit-gated reads.
module frame_streamer
  import vga_stream_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int DATA_W = PIX_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] src_data,
  output logic              src_valid,
  input  logic              src_ready,
  output logic              src_sop,
  output logic              src_eop,
  output logic              frame_done
);

  localparam int CW = cnt_w(WIDTH);
  localparam int RW = cnt_w(HEIGHT);
  localparam int QW = $clog2(FIFO_DEPTH + 1);

  state_t        state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          inflight;
  logic          sop_d;
  logic          eop_d;
  logic [QW-1:0] fifo_count;
  beat_t         head;
  beat_t         push_beat;
  logic          issue;
  logic          pop;
  logic          first_px;
  logic          last_px;

  assign first_px = (col == '0) && (row == '0);
  assign last_px  = (col == CW'(WIDTH - 1)) && (row == RW'(HEIGHT - 1));

  // Credit check uses only registered terms, so src_ready never reaches rd_addr combinationally.
  assign issue = (state == ST_STREAM) &&
                 ((int'(fifo_count) + int'(inflight)) < FIFO_DEPTH);

  assign src_valid = (fifo_count != '0);
  assign pop       = src_valid & src_ready;
  assign src_data  = DATA_W'(head.data);
  assign src_sop   = src_valid & head.sop;
  assign src_eop   = src_valid & head.eop;

  assign push_beat = '{data: pixel_t'(rd_data), sop: sop_d, eop: eop_d};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      rd_addr    <= '0;
      col        <= '0;
      row        <= '0;
      inflight   <= 1'b0;
      sop_d      <= 1'b0;
      eop_d      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      inflight   <= issue;
      sop_d      <= issue & first_px;
      eop_d      <= issue & last_px;
      frame_done <= pop & head.eop;

      if (issue) begin
        if (last_px) begin
          rd_addr <= '0;
          col     <= '0;
          row     <= '0;
        end else begin
          rd_addr <= rd_addr + 1'b1;
          if (col == CW'(WIDTH - 1)) begin
            col <= '0;
            row <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
      end

      // enable only matters between frames: in IDLE and when the eop beat leaves.
      case (state)
        ST_IDLE:   if (enable) state <= ST_STREAM;
        ST_STREAM: if (issue && last_px) state <= ST_DRAIN;
        ST_DRAIN:  if (pop && head.eop) state <= enable ? ST_STREAM : ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  stream_skid_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (inflight),
    .push_beat (push_beat),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_frame_streamer.sv
// Directed bench for frame_streamer on a 4x3 frame with a 1-cycle-latency RAM model.
module tb_frame_streamer;
  import vga_stream_pkg::*;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int N  = W * H;
  localparam int AW = 4;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic          src_ready;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic [DW-1:0] src_data;
  logic          src_valid;
  logic          src_sop;
  logic          src_eop;
  logic          frame_done;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  // Frame buffer model: pixel i holds 0xA00 + i.
  always @(posedge clk) rd_data <= 12'hA00 + DW'(rd_addr);

  frame_streamer #(.WIDTH(W), .HEIGHT(H), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .src_data   (src_data),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .src_sop    (src_sop),
    .src_eop    (src_eop),
    .frame_done (frame_done)
  );

  function automatic logic [DW-1:0] pix(input int i);
    return 12'hA00 + DW'(i % N);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n   = 1'b0;
    enable    = 1'b0;
    src_ready = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b1; src_ready = 1'b1;
    repeat (3) tick();
    checks++; if (rd_addr !== '0) $display("FAIL reset_rd_addr: got %0h expected 0", rd_addr); else passes++;
    checks++; if (src_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", src_valid); else passes++;
    checks++; if ({src_sop, src_eop} !== 2'b00) $display("FAIL reset_sop_eop: got %b expected 00", {src_sop, src_eop}); else passes++;
    checks++; if (src_data !== '0) $display("FAIL reset_data: got %0h expected 0", src_data); else passes++;
    checks++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b expected 0", frame_done); else passes++;
    checks++; if (dut.state !== ST_IDLE) $display("FAIL reset_state: got %0d expected %0d", dut.state, ST_IDLE); else passes++;
  endtask

  task automatic test_idle_hold();
    int bad = 0;
    reset_n = 1'b1; enable = 1'b0; src_ready = 1'b1;
    repeat (100) begin
      tick();
      if (rd_addr !== '0 || src_valid !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) $display("FAIL idle_hold: got %0d active cycles expected 0", bad); else passes++;
  endtask

  task automatic test_full_rate();
    int first_valid = -1;
    int errs = 0;
    int done_f1 = 0;
    int bcyc[$];
    logic [DW-1:0] bdat[$];
    logic bsop[$];
    logic beop[$];
    int done_cyc[$];
    apply_reset();
    enable = 1'b1; src_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (src_valid && first_valid < 0) first_valid = c;
      if (src_valid && src_ready) begin
        bcyc.push_back(c); bdat.push_back(src_data); bsop.push_back(src_sop); beop.push_back(src_eop);
      end
      if (frame_done) done_cyc.push_back(c);
      tick();
    end
    for (int k = 0; k < bdat.size(); k++)
      if (bdat[k] !== pix(k) || bsop[k] !== (k % N == 0) || beop[k] !== (k % N == N - 1)) errs++;
    checks++; if (first_valid !== 3) $display("FAIL full_first_latency: got %0d expected 3", first_valid); else passes++;
    checks++; if (bdat.size() < 24) $display("FAIL full_beat_count: got %0d expected >= 24", bdat.size()); else passes++;
    checks++; if (errs !== 0) $display("FAIL full_sequence: got %0d bad beats expected 0", errs); else passes++;
    if (bdat.size() >= 24) begin
      foreach (done_cyc[i]) if (done_cyc[i] < bcyc[23] + 1) done_f1++;
      checks++; if (bcyc[11] - bcyc[0] !== 11) $display("FAIL full_throughput: got span %0d expected 11", bcyc[11] - bcyc[0]); else passes++;
      checks++; if (bcyc[12] - bcyc[11] > 4) $display("FAIL full_b2b_gap: got %0d expected <= 4", bcyc[12] - bcyc[11]); else passes++;
      checks++; if (done_f1 !== 1) $display("FAIL full_done_once: got %0d pulses expected 1", done_f1); else passes++;
      checks++;
      if (done_cyc.size() == 0 || done_cyc[0] !== bcyc[11] + 1)
        $display("FAIL full_done_timing: got %0d expected %0d", (done_cyc.size() == 0) ? -1 : done_cyc[0], bcyc[11] + 1);
      else passes++;
    end
  endtask

  task automatic test_random_ready();
    int k = 0, seq_err = 0, unstable = 0, over = 0;
    logic pv = 1'b0, pa = 1'b0, ps = 1'b0, pe = 1'b0;
    logic [DW-1:0] pd = '0;
    apply_reset();
    enable = 1'b1;
    for (int c = 0; c < 400; c++) begin
      src_ready = 1'($urandom_range(0, 1));
      if (pv && !pa && (src_valid !== 1'b1 || src_data !== pd || src_sop !== ps || src_eop !== pe)) unstable++;
      if (int'(dut.fifo_count) + int'(dut.inflight) > 3) over++;
      if (src_valid && src_ready) begin
        if (src_data !== pix(k) || src_sop !== (k % N == 0) || src_eop !== (k % N == N - 1)) seq_err++;
        k++;
      end
      pv = src_valid; pa = src_valid & src_ready; pd = src_data; ps = src_sop; pe = src_eop;
      tick();
    end
    checks++; if (seq_err !== 0) $display("FAIL rand_sequence: got %0d bad beats expected 0", seq_err); else passes++;
    checks++; if (unstable !== 0) $display("FAIL rand_stability: got %0d violations expected 0", unstable); else passes++;
    checks++; if (over !== 0) $display("FAIL rand_credit: got %0d overflows expected 0", over); else passes++;
    checks++; if (k < 60) $display("FAIL rand_progress: got %0d beats expected >= 60", k); else passes++;
  endtask

  task automatic test_stall();
    int k = 0, c = 0, errs = 0, adv = 0, bad = 0;
    logic [AW-1:0] prev_addr;
    apply_reset();
    enable = 1'b1; src_ready = 1'b1;
    while (k < 5 && c < 40) begin
      if (src_valid && src_ready) begin
        if (src_data !== pix(k)) errs++;
        k++;
      end
      tick(); c++;
    end
    src_ready = 1'b0;
    prev_addr = rd_addr;
    repeat (20) begin
      if (rd_addr !== prev_addr) adv++;
      prev_addr = rd_addr;
      if (src_valid !== 1'b1 || src_data !== pix(5) || src_sop !== 1'b0) bad++;
      tick();
    end
    src_ready = 1'b1; c = 0;
    while (k < N && c < 40) begin
      if (src_valid && src_ready) begin
        if (src_data !== pix(k) || src_eop !== (k == N - 1)) errs++;
        k++;
      end
      tick(); c++;
    end
    checks++; if (adv > 3) $display("FAIL stall_addr_advance: got %0d expected <= 3", adv); else passes++;
    checks++; if (bad !== 0) $display("FAIL stall_head_stable: got %0d bad cycles expected 0", bad); else passes++;
    checks++; if (errs !== 0) $display("FAIL stall_sequence: got %0d bad beats expected 0", errs); else passes++;
    checks++; if (k !== N) $display("FAIL stall_frame_complete: got %0d beats expected %0d", k, N); else passes++;
  endtask

  task automatic test_enable_drop();
    int k = 0, errs = 0, after = 0, done_n = 0;
    logic saw_eop = 1'b0;
    apply_reset();
    enable = 1'b1; src_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (saw_eop && src_valid) after++;
      if (src_valid && src_ready) begin
        if (src_data !== pix(k) || src_sop !== (k == 0) || src_eop !== (k == N - 1)) errs++;
        if (src_eop) saw_eop = 1'b1;
        if (k == 5) enable = 1'b0;
        k++;
      end
      if (frame_done) done_n++;
      tick();
    end
    checks++; if (k !== N) $display("FAIL endrop_beats: got %0d expected %0d", k, N); else passes++;
    checks++; if (errs !== 0 || saw_eop !== 1'b1) $display("FAIL endrop_sequence: got %0d bad beats, eop %b expected 0, 1", errs, saw_eop); else passes++;
    checks++; if (after !== 0) $display("FAIL endrop_quiet: got %0d valid cycles after eop expected 0", after); else passes++;
    checks++; if (done_n !== 1) $display("FAIL endrop_done: got %0d pulses expected 1", done_n); else passes++;
    checks++; if (dut.state !== ST_IDLE) $display("FAIL endrop_state: got %0d expected %0d", dut.state, ST_IDLE); else passes++;
  endtask

  task automatic test_reset_mid();
    int k = 0, c = 0;
    logic got = 1'b0, gs = 1'b0;
    logic [DW-1:0] gd = '0;
    apply_reset();
    enable = 1'b1; src_ready = 1'b1;
    while (k < 8 && c < 40) begin
      if (src_valid && src_ready) k++;
      tick(); c++;
    end
    reset_n = 1'b0;
    tick();
    checks++; if (rd_addr !== '0) $display("FAIL midrst_rd_addr: got %0h expected 0", rd_addr); else passes++;
    checks++; if (src_valid !== 1'b0) $display("FAIL midrst_valid: got %b expected 0", src_valid); else passes++;
    checks++;
    if ({src_sop, src_eop, frame_done} !== 3'b000 || src_data !== '0)
      $display("FAIL midrst_outputs: got sop/eop/done %b data %0h expected 000 and 0", {src_sop, src_eop, frame_done}, src_data);
    else passes++;
    reset_n = 1'b1; c = 0;
    while (!got && c < 30) begin
      if (src_valid && src_ready) begin
        got = 1'b1; gd = src_data; gs = src_sop;
      end else begin
        tick(); c++;
      end
    end
    checks++; if (got !== 1'b1) $display("FAIL midrst_restart: got no beat expected one within 30 cycles"); else passes++;
    checks++; if (gd !== pix(0) || gs !== 1'b1) $display("FAIL midrst_first_beat: got data %0h sop %b expected %0h 1", gd, gs, pix(0)); else passes++;
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; src_ready = 1'b0;
    test_reset();
    test_idle_hold();
    test_full_rate();
    test_random_ready();
    test_stall();
    test_enable_drop();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
